// File: rtl/bnn_add_pkg.sv
// Shared helpers for the streaming adder tree: tree sizing and wrap/clamp addition.
package bnn_add_pkg;

  localparam int unsigned WIDTH_IN_DEF = 8;
  localparam int unsigned ELEM_W       = WIDTH_IN_DEF + 11;

  typedef logic signed [ELEM_W-1:0] elem_t;

  function automatic int unsigned clog4(input int unsigned n);
    int unsigned s;
    int unsigned cap;
    s   = 0;
    cap = 1;
    while (cap < n) begin
      cap = cap * 4;
      s++;
    end
    return s;
  endfunction

  // Number of partial sums present after k reduction levels.
  function automatic int unsigned level_n(input int unsigned lanes, input int unsigned k);
    int unsigned n;
    n = lanes;
    for (int unsigned i = 0; i < k; i++) n = (n + 3) / 4;
    return n;
  endfunction

  // Operands are w-bit values sign-extended to 64 bits; result is w-bit wrapped or clamped.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w,
                                                 input bit sat);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sat) begin
      if (sum > hi) return hi;
      if (sum < lo) return lo;
      return sum;
    end
    return (sum <<< (64 - w)) >>> (64 - w);
  endfunction

endpackage

// File: rtl/add_tree_stage.sv
// One registered 4-ary reduction level; valid and last flags travel alongside the sums.
module add_tree_stage #(
  parameter int unsigned N_IN = 16,
  parameter int unsigned W    = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic                         in_last,
  input  logic [N_IN*W-1:0]            in_data,
  output logic                         out_valid,
  output logic                         out_last,
  output logic [((N_IN+3)/4)*W-1:0]    out_data
);

  localparam int unsigned N_OUT = (N_IN + 3) / 4;

  logic [N_OUT*4*W-1:0] padded;
  logic [N_OUT*W-1:0]   sums;

  // Zero-padding supplies the missing inputs of a short final group.
  assign padded = (N_OUT*4*W)'(in_data);

  always_comb begin
    sums = '0;
    for (int unsigned g = 0; g < N_OUT; g++)
      for (int unsigned j = 0; j < 4; j++)
        sums[g*W +: W] = sums[g*W +: W] + padded[(g*4+j)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_last  <= in_last;
      out_data  <= sums;
    end
  end

endmodule

// File: rtl/add_tree_accum.sv
// Streaming signed vector reduction: beat counter, last-beat lane mask, adder tree, accumulator.
module add_tree_accum
  import bnn_add_pkg::*;
#(
  parameter int unsigned WIDTH_IN = 8,
  parameter int unsigned LANES    = 16,
  parameter int unsigned N_TOTAL  = 784,
  parameter int unsigned ACC_W    = WIDTH_IN + 11,
  parameter int unsigned SATURATE = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [LANES*(WIDTH_IN+11)-1:0]  in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [ACC_W-1:0]         out_sum
);

  localparam int unsigned EW     = WIDTH_IN + 11;
  localparam int unsigned BEATS  = (N_TOTAL + LANES - 1) / LANES;
  localparam int unsigned S      = clog4(LANES);
  localparam int unsigned LAST_N = N_TOTAL - (BEATS - 1) * LANES;
  localparam int unsigned CW     = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CW-1:0]            cnt;
  logic                     advance;
  logic                     accept;
  logic                     is_last;
  logic [LANES*ACC_W-1:0]   ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  tsum;
  logic signed [ACC_W-1:0]  nsum;

  // A pending, unconsumed result freezes the entire pipeline.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = rst_n && advance;
  assign accept   = in_valid && in_ready;
  assign is_last  = (cnt == CW'(BEATS - 1));

  always_comb begin
    ext = '0;
    for (int unsigned i = 0; i < LANES; i++)
      if (!is_last || i < LAST_N)
        ext[i*ACC_W +: ACC_W] = ACC_W'($signed(in_data[i*EW +: EW]));
  end

  // Level 0 is the masked input; each later level is one registered reduction.
  for (genvar k = 0; k <= S; k++) begin : lvl
    localparam int unsigned N = level_n(LANES, k);
    logic [N*ACC_W-1:0] d;
    logic               v;
    logic               l;
    if (k == 0) begin : src
      assign d = ext;
      assign v = accept;
      assign l = is_last;
    end else begin : red
      add_tree_stage #(
        .N_IN (level_n(LANES, k - 1)),
        .W    (ACC_W)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (advance),
        .in_valid  (lvl[k-1].v),
        .in_last   (lvl[k-1].l),
        .in_data   (lvl[k-1].d),
        .out_valid (v),
        .out_last  (l),
        .out_data  (d)
      );
    end
  end

  assign tsum = lvl[S].d;
  assign nsum = ACC_W'(sat_add(64'(acc), 64'(tsum), ACC_W, SATURATE != 0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (advance && lvl[S].v) begin
        if (lvl[S].l) begin
          out_sum   <= nsum;
          out_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= nsum;
        end
      end
      if (accept) cnt <= is_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_add_tree_accum.sv
// Directed and randomized checks of add_tree_accum against a queue-based vector-sum model.
module tb_add_tree_accum;

  localparam int unsigned LN  = 16;
  localparam int unsigned EW0 = 19;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default configuration
  logic                    v0  = 1'b0;
  logic                    or0 = 1'b1;
  logic                    rdy0, ov0;
  logic [LN*EW0-1:0]       d0  = '0;
  logic signed [18:0]      s0;

  // N_TOTAL=20: last beat keeps only lanes 0..3
  logic                    v1  = 1'b0;
  logic                    or1 = 1'b1;
  logic                    rdy1, ov1;
  logic [LN*19-1:0]        d1  = '0;
  logic signed [18:0]      s1;

  // ACC_W=12 pair: clamping and wrapping, fed identical stimulus
  logic                    v2  = 1'b0;
  logic                    or2 = 1'b1;
  logic                    rdy2, rdy3, ov2, ov3;
  logic [LN*12-1:0]        d2  = '0;
  logic signed [11:0]      s2, s3;

  add_tree_accum #(.WIDTH_IN(8), .LANES(16), .N_TOTAL(784), .ACC_W(19), .SATURATE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_sum(s0));

  add_tree_accum #(.WIDTH_IN(8), .LANES(16), .N_TOTAL(20), .ACC_W(19), .SATURATE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_sum(s1));

  add_tree_accum #(.WIDTH_IN(1), .LANES(16), .N_TOTAL(784), .ACC_W(12), .SATURATE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .out_valid(ov2), .out_ready(or2), .out_sum(s2));

  add_tree_accum #(.WIDTH_IN(1), .LANES(16), .N_TOTAL(784), .ACC_W(12), .SATURATE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy3), .in_data(d2),
    .out_valid(ov3), .out_ready(or2), .out_sum(s3));

  int     total = 0;
  int     bad   = 0;
  longint q[$];
  logic   rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap19(input longint x);
    logic signed [18:0] t;
    t = x[18:0];
    return t;
  endfunction

  function automatic longint wrap12(input longint x);
    logic signed [11:0] t;
    t = x[11:0];
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) or0 = ($urandom_range(0, 3) != 0);
  endtask

  // mode 0: every element = val; mode 1: random elements in [-1000,1000].
  // The expected sum is queued once the 49th beat of a vector is accepted.
  task automatic send_vec(input int mode, input int val, input int nbeats, input int gap_pct,
                          output int cyc);
    longint vsum;
    longint bsum;
    int     beat;
    int     e;
    logic   took;
    vsum = 0;
    beat = 0;
    cyc  = 0;
    while (beat < nbeats && cyc < 3000) begin
      bsum = 0;
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        v0 = 1'b0;
      end else begin
        v0 = 1'b1;
        for (int l = 0; l < int'(LN); l++) begin
          e = (mode == 0) ? val : int'($urandom_range(0, 2000)) - 1000;
          d0[l*EW0 +: EW0] = EW0'(e);
          bsum += e;
        end
      end
      @(negedge clk);
      took = v0 && rdy0;
      tick();
      cyc++;
      if (took) begin
        vsum += bsum;
        if (beat == 48) q.push_back(wrap19(vsum));
        beat++;
      end
    end
    v0 = 1'b0;
    if (beat < nbeats) chk("send_timeout", beat, nbeats);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Scoreboard: every handshake pops the oldest expected sum; a stalled result must not move.
  logic               prev_stall = 1'b0;
  logic signed [18:0] prev_sum   = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) chk("hold_sum", s0, prev_sum);
      if (ov0 && or0) begin
        if (q.size() == 0) chk("out_with_empty_queue", q.size(), 1);
        else chk("out_sum", s0, q.pop_front());
      end
      prev_stall <= ov0 && !or0;
      prev_sum   <= s0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int                 cyc, c1, c2, n, a0, val;
    logic signed [18:0] held;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", rdy0, 0);
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_sum", s0, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", rdy0, 1);
    tick();

    // 49 beats of +1: sum 784, out_valid three cycles after the last beat
    send_vec(0, 1, 49, 0, cyc);
    chk("ones_cycles", cyc, 49);
    @(negedge clk);
    chk("lat_c1_valid", ov0, 0);
    tick();
    @(negedge clk);
    chk("lat_c2_valid", ov0, 0);
    tick();
    @(negedge clk);
    chk("lat_c3_valid", ov0, 1);
    chk("ones_sum", s0, 784);
    tick();

    // Back-to-back vectors without a bubble
    send_vec(0, -1, 49, 0, c1);
    send_vec(0, 3, 49, 0, c2);
    chk("b2b_cycles_first", c1, 49);
    chk("b2b_cycles_second", c2, 49);
    drain();

    // Result held with out_ready low while the next vector is offered
    send_vec(1, 0, 49, 0, cyc);
    or0 = 1'b0;
    fork
      send_vec(1, 0, 49, 0, cyc);
      begin
        n = 0;
        @(negedge clk);
        while (!ov0 && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("stall_valid", ov0, 1);
        held = s0;
        repeat (5) begin
          chk("stall_in_ready", rdy0, 0);
          chk("stall_sum", s0, held);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        or0 = 1'b1;
      end
    join
    drain();

    // Random data, random valid gaps and random out_ready
    rnd_ready = 1'b1;
    repeat (4) send_vec(1, 0, 49, 25, cyc);
    drain();
    rnd_ready = 1'b0;
    or0 = 1'b1;
    tick();

    // Reset in the middle of a vector discards the partial sum
    send_vec(0, 1, 20, 0, cyc);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_out_valid", ov0, 0);
    chk("midrst_in_ready", rdy0, 0);
    chk("midrst_out_sum", s0, 0);
    tick();
    rst_n = 1'b1;
    send_vec(0, 1, 49, 0, cyc);
    drain();

    // Last-beat masking with N_TOTAL=20
    repeat (2) begin
      a0 = int'($urandom_range(0, 500)) - 250;
      v1 = 1'b1;
      for (int l = 0; l < int'(LN); l++) d1[l*19 +: 19] = 19'(a0);
      @(negedge clk);
      chk("mask_ready_b0", rdy1, 1);
      tick();
      for (int l = 0; l < int'(LN); l++) d1[l*19 +: 19] = 19'((l < 4) ? 2 : 1000);
      @(negedge clk);
      chk("mask_ready_b1", rdy1, 1);
      tick();
      v1 = 1'b0;
      for (int l = 0; l < int'(LN); l++) d1[l*19 +: 19] = 19'(7777);
      n = 0;
      @(negedge clk);
      while (!ov1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("mask_valid", ov1, 1);
      chk("mask_sum", s1, wrap19(16 * a0 + 8));
      tick();
    end

    // ACC_W=12: 49 beats of +/-100 clamp or wrap
    for (int t = 0; t < 2; t++) begin
      val = (t == 0) ? 100 : -100;
      v2 = 1'b1;
      for (int l = 0; l < int'(LN); l++) d2[l*12 +: 12] = 12'(val);
      @(negedge clk);
      chk("acc12_ready", rdy2, 1);
      repeat (49) tick();
      v2 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!ov2 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("acc12_valid_sat", ov2, 1);
      chk("acc12_valid_wrap", ov3, 1);
      chk("acc12_sat_sum", s2, (val > 0) ? 2047 : -2048);
      chk("acc12_wrap_sum", s3, wrap12(longint'(49 * 16 * val)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
